// File: rtl/chunk_subtractor.sv
// Purpose: sequential N-bit subtractor d = a - b - bin, W bits per clock, LSB chunk first.
// Latency: K+1 edges from acceptance to out_valid (K = N/W); one op per K+2 cycles at best.
// Backpressure: in_ready is low from acceptance until the result is taken; DONE holds under out_ready=0.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake carrying a, b, bin
//   out_valid/out_ready  result handshake carrying d, bout, zero, ovf
//   d                    difference (a - b - bin) mod 2^N
//   bout                 unsigned borrow out (a < b + bin)
//   zero                 d == 0
//   ovf                  signed overflow of the subtraction
module chunk_subtractor #(
  parameter int N = 64,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         zero,
  output logic         ovf
);

  localparam int K  = N / W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    a_q, b_q;
  logic            borrow_q;
  logic [IW-1:0]   idx_q;
  logic            last_chunk;
  logic [W-1:0]    a_chunk, b_chunk;
  logic [W:0]      diff;
  logic [N-1:0]    d_nxt;

  // Chunk datapath: one W-bit subtract with the borrow appearing in the extra top bit.
  always_comb begin
    a_chunk    = a_q[int'(idx_q)*W +: W];
    b_chunk    = b_q[int'(idx_q)*W +: W];
    diff       = {1'b0, a_chunk} - {1'b0, b_chunk} - {{W{1'b0}}, borrow_q};
    d_nxt      = d;
    d_nxt[int'(idx_q)*W +: W] = diff[W-1:0];
    last_chunk = (idx_q == IW'(K - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Handshake outputs decode from the state register only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      d        <= '0;
      bout     <= 1'b0;
      zero     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_q      <= a;
        b_q      <= b;
        borrow_q <= bin;
        idx_q    <= '0;
      end
      if (state == RUN) begin
        d        <= d_nxt;
        borrow_q <= diff[W];
        idx_q    <= idx_q + IW'(1);
        // Flags only change on the final chunk so they stay valid through DONE and after.
        if (last_chunk) begin
          bout <= diff[W];
          zero <= (d_nxt == '0);
          ovf  <= (a_q[N-1] ^ b_q[N-1]) & (diff[W-1] ^ a_q[N-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_chunk_subtractor.sv
module tb_chunk_subtractor;

  typedef struct packed {
    logic [63:0] d;
    logic        bout;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, bin, out_valid, out_ready, bout, zero, ovf;
  logic [63:0] a, b, d;

  logic        in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8, zero8, ovf8;
  logic [7:0]  a8, b8, d8;

  exp_t q64[$];
  exp_t q8[$];
  exp_t e64, e8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chunk_subtractor #(.N(64), .W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .zero(zero), .ovf(ovf)
  );

  chunk_subtractor #(.N(8), .W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .d(d8), .bout(bout8), .zero(zero8), .ovf(ovf8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitors: pop and compare on each result handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q64.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result64 d=%h", d);
      end else begin
        e64 = q64.pop_front();
        chk("d64", d, e64.d);
        chk("bout64", {63'd0, bout}, {63'd0, e64.bout});
        chk("zero64", {63'd0, zero}, {63'd0, e64.zero});
        chk("ovf64", {63'd0, ovf}, {63'd0, e64.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result8 d=%h", d8);
      end else begin
        e8 = q8.pop_front();
        chk("d8", {56'd0, d8}, e8.d);
        chk("bout8", {63'd0, bout8}, {63'd0, e8.bout});
        chk("zero8", {63'd0, zero8}, {63'd0, e8.zero});
        chk("ovf8", {63'd0, ovf8}, {63'd0, e8.ovf});
      end
    end
  end

  task automatic run64(input logic [63:0] av, input logic [63:0] bv, input logic bi,
                       input logic [63:0] ed, input logic eb, input logic ez,
                       input logic eo, input int hold);
    int   n;
    logic irbad;
    exp_t ex;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ex.d = ed; ex.bout = eb; ex.zero = ez; ex.ovf = eo;
    q64.push_back(ex);
    out_ready = (hold == 0);
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble operand pins; the latched copy must be used.
    in_valid = 1'b0; a = ~av; b = av ^ bv; bin = ~bi;
    n = 1;
    irbad = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) irbad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("latency64", n, 9);
    chk("in_ready_busy64", {63'd0, irbad}, 64'd0);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        chk("hold_d", d, ed);
        chk("hold_flags", {61'd0, bout, zero, ovf}, {61'd0, eb, ez, eo});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_hs_out_valid", {63'd0, out_valid}, 64'd0);
      chk("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
    end else begin
      @(posedge clk); #1;
    end
    chk("d_held_after_hs", d, ed);
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                      input logic [7:0] ed, input logic eb, input logic ez, input logic eo);
    int   n;
    exp_t ex;
    n = 0;
    while (!in_ready8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ex.d = {56'd0, ed}; ex.bout = eb; ex.zero = ez; ex.ovf = eo;
    q8.push_back(ex);
    out_ready8 = 1'b1;
    a8 = av; b8 = bv; bin8 = bi; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = ~av; b8 = av ^ bv;
    n = 1;
    while (!out_valid8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency8", n, 2);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "bench timed out");
  end

  initial begin
    int   n;
    logic seen;
    rst_n = 1'b0;
    in_valid = 1'b1; a = 64'd7; b = 64'd3; bin = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = 8'd0; b8 = 8'd0; bin8 = 1'b0; out_ready8 = 1'b1;

    // Reset state, with an operand offered that must be ignored.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_d", d, 64'd0);
    chk("rst_flags", {61'd0, bout, zero, ovf}, 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_in_ready", {63'd0, in_ready}, 64'd1);

    run64(64'd120, 64'd80, 1'b0, 64'd40, 1'b0, 1'b0, 1'b0, 0);
    run64(64'h100, 64'd1, 1'b0, 64'hFF, 1'b0, 1'b0, 1'b0, 0);
    run64(64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
    run64(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 0);
    run64(64'd5, 64'd4, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 0);
    run64(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
          64'h0246_8ACF_1357_9BCF, 1'b0, 1'b0, 1'b0, 5);

    // Abort mid-operation with an asynchronous reset.
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    a = 64'd2000000000; b = 64'd100000000; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_d", d, 64'd0);
    chk("abort_flags", {61'd0, bout, zero, ovf}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_out_valid", {63'd0, seen}, 64'd0);
    run64(64'd1500000000, 64'd500000000, 1'b0, 64'd1000000000, 1'b0, 1'b0, 1'b0, 0);

    // Single-chunk instance.
    run8(8'd200, 8'd50, 1'b0, 8'd150, 1'b0, 1'b0, 1'b0);
    run8(8'd50, 8'd200, 1'b0, 8'd106, 1'b1, 1'b0, 1'b0);

    n = 0;
    while ((q64.size() != 0 || q8.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q64.size() != 0 || q8.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL results_missing pending64=%0d pending8=%0d required=0", q64.size(), q8.size());
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
